// File: rtl/babbage_sweep_ctrl_if.sv
// Engine / bin2bcd handshake bundle for the sweep controller.
// master = controller side, slave = engine and bin2bcd side.
interface babbage_sweep_ctrl_if #(
  parameter int unsigned N_W   = 6,
  parameter int unsigned OUT_W = 20
);
  logic             eng_start;
  logic [N_W-1:0]   eng_in;
  logic             eng_done;
  logic [OUT_W-1:0] eng_out;
  logic             bcd_start;
  logic [13:0]      bcd_bin;
  logic             bcd_done;

  modport master (
    output eng_start, eng_in, bcd_start, bcd_bin,
    input  eng_done, eng_out, bcd_done
  );

  modport slave (
    input  eng_start, eng_in, bcd_start, bcd_bin,
    output eng_done, eng_out, bcd_done
  );
endinterface

// File: rtl/babbage_sweep_ctrl.sv
// Sweeps the difference engine over n_first..n_last, converting and dwelling on each result.
// Optional macro SWEEP_CONT_EN: wrap back to n_first at n_last and run until stop.
module babbage_sweep_ctrl #(
  parameter int unsigned DWELL_CYC = 50_000_000,
  parameter int unsigned N_W       = 6,
  parameter int unsigned OUT_W     = 20,
  parameter int unsigned BCD_MAX   = 9999
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [N_W-1:0]       i_n_first,
  input  logic [N_W-1:0]       i_n_last,
  babbage_sweep_ctrl_if.master bus,
  output logic [N_W-1:0]       o_cur_n,
  output logic                 o_ovf,
  output logic                 o_busy,
  output logic                 o_range_err,
  output logic                 o_done_tick
);

  localparam int unsigned    CNT_W     = $clog2(DWELL_CYC + 1);
  localparam logic [OUT_W-1:0] BCD_MAX_W = OUT_W'(BCD_MAX);

  typedef enum logic [1:0] {StIdle, StCalc, StConv, StDwell} state_e;

  state_e           r_state;
  logic [N_W-1:0]   r_cur_n;
  logic [N_W-1:0]   r_n_end;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stop_pend;
  logic             r_ovf;
  logic             r_eng_start;
  logic             r_bcd_start;
  logic [13:0]      r_bcd_bin;
  logic             r_range_err;
  logic             r_done_tick;
`ifdef SWEEP_CONT_EN
  logic [N_W-1:0]   r_n_first;
`endif

  // A stop landing on the expiry cycle itself still ends the sweep.
  logic w_stop_any;
  assign w_stop_any = r_stop_pend | i_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cur_n     <= '0;
      r_n_end     <= '0;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
      r_ovf       <= 1'b0;
      r_eng_start <= 1'b0;
      r_bcd_start <= 1'b0;
      r_bcd_bin   <= '0;
      r_range_err <= 1'b0;
      r_done_tick <= 1'b0;
`ifdef SWEEP_CONT_EN
      r_n_first   <= '0;
`endif
    end else begin
      r_eng_start <= 1'b0;
      r_bcd_start <= 1'b0;
      r_range_err <= 1'b0;
      r_done_tick <= 1'b0;
      if (i_stop && (r_state != StIdle)) r_stop_pend <= 1'b1;

      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (i_n_first <= i_n_last) begin
              r_cur_n     <= i_n_first;
              r_n_end     <= i_n_last;
              r_stop_pend <= 1'b0;
              r_ovf       <= 1'b0;
              r_eng_start <= 1'b1;
              r_state     <= StCalc;
`ifdef SWEEP_CONT_EN
              r_n_first   <= i_n_first;
`endif
            end else begin
              r_range_err <= 1'b1;
            end
          end
        end
        StCalc: begin
          if (bus.eng_done) begin
            if (bus.eng_out > BCD_MAX_W) begin
              r_bcd_bin <= 14'(BCD_MAX);
              r_ovf     <= 1'b1;
            end else begin
              r_bcd_bin <= bus.eng_out[13:0];
              r_ovf     <= 1'b0;
            end
            r_bcd_start <= 1'b1;
            r_state     <= StConv;
          end
        end
        StConv: begin
          if (bus.bcd_done) begin
            r_cnt   <= CNT_W'(DWELL_CYC - 1);
            r_state <= StDwell;
          end
        end
        StDwell: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (w_stop_any) begin
            r_done_tick <= 1'b1;
            r_state     <= StIdle;
          end else if (r_cur_n == r_n_end) begin
`ifdef SWEEP_CONT_EN
            r_cur_n     <= r_n_first;
            r_eng_start <= 1'b1;
            r_state     <= StCalc;
`else
            r_done_tick <= 1'b1;
            r_state     <= StIdle;
`endif
          end else begin
            r_cur_n     <= r_cur_n + N_W'(1);
            r_eng_start <= 1'b1;
            r_state     <= StCalc;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.eng_start = r_eng_start;
  assign bus.eng_in    = r_cur_n;
  assign bus.bcd_start = r_bcd_start;
  assign bus.bcd_bin   = r_bcd_bin;
  assign o_cur_n       = r_cur_n;
  assign o_ovf         = r_ovf;
  assign o_busy        = (r_state != StIdle);
  assign o_range_err   = r_range_err;
  assign o_done_tick   = r_done_tick;

endmodule

// File: tb/tb_babbage_sweep_ctrl.sv
// Directed bench for babbage_sweep_ctrl with engine and bin2bcd behavioural models.
module tb_babbage_sweep_ctrl;
  localparam int unsigned N_W   = 6;
  localparam int unsigned OUT_W = 20;

  logic           clk       = 1'b0;
  logic           reset     = 1'b0;
  logic           i_start   = 1'b0;
  logic           i_stop    = 1'b0;
  logic [N_W-1:0] i_n_first = '0;
  logic [N_W-1:0] i_n_last  = '0;
  logic [N_W-1:0] o_cur_n;
  logic           o_ovf, o_busy, o_range_err, o_done_tick;

  babbage_sweep_ctrl_if #(.N_W(N_W), .OUT_W(OUT_W)) bus ();

  babbage_sweep_ctrl #(
    .DWELL_CYC(4), .N_W(N_W), .OUT_W(OUT_W), .BCD_MAX(9999)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_n_first  (i_n_first),
    .i_n_last   (i_n_last),
    .bus        (bus),
    .o_cur_n    (o_cur_n),
    .o_ovf      (o_ovf),
    .o_busy     (o_busy),
    .o_range_err(o_range_err),
    .o_done_tick(o_done_tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;
  int eng_cnt = 0, bcd_cnt = 0, done_cnt = 0, rerr_cnt = 0;
  int bcd_q[$];
  bit force_big = 1'b0;
  logic [N_W-1:0] e_n;
  int e_ctr, b_ctr;

  function automatic logic [OUT_W-1:0] f_eng(input logic [N_W-1:0] n);
    int ni;
    ni = int'(n);
    return OUT_W'(2 * ni * ni + 3 * ni + 5);
  endfunction

  // Engine model: result about 3 cycles after eng_start.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.eng_done <= 1'b0;
      bus.eng_out  <= '0;
      e_n          <= '0;
      e_ctr        <= 0;
    end else begin
      bus.eng_done <= 1'b0;
      if (bus.eng_start) begin
        e_n   <= bus.eng_in;
        e_ctr <= 3;
      end else if (e_ctr == 1) begin
        bus.eng_done <= 1'b1;
        bus.eng_out  <= force_big ? OUT_W'(12000) : f_eng(e_n);
        e_ctr        <= 0;
      end else if (e_ctr > 1) begin
        e_ctr <= e_ctr - 1;
      end
    end
  end

  // bin2bcd model: done about 5 cycles after bcd_start.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bcd_done <= 1'b0;
      b_ctr        <= 0;
    end else begin
      bus.bcd_done <= 1'b0;
      if (bus.bcd_start) b_ctr <= 5;
      else if (b_ctr == 1) begin
        bus.bcd_done <= 1'b1;
        b_ctr        <= 0;
      end else if (b_ctr > 1) b_ctr <= b_ctr - 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.eng_start) eng_cnt = eng_cnt + 1;
      if (bus.bcd_start) begin
        bcd_cnt = bcd_cnt + 1;
        bcd_q.push_back(int'(bus.bcd_bin));
      end
      if (o_done_tick) done_cnt = done_cnt + 1;
      if (o_range_err) rerr_cnt = rerr_cnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int nf, input int nl);
    @(negedge clk);
    i_n_first = N_W'(nf);
    i_n_last  = N_W'(nl);
    i_start   = 1'b1;
    @(negedge clk);
    i_start   = 1'b0;
  endtask

  task automatic pulse_stop();
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int r0, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done_cnt != d0 || rerr_cnt != r0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    int nf; int nl; bit big;
    int pts; int dones; int rerrs; int last_bcd; int last_ovf; int last_n;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    bit   ok;
    int   e0, b0, d0, r0, e1;

    vt[0] = '{nf: 0,  nl: 3,  big: 0, pts: 4, dones: 1, rerrs: 0, last_bcd: 32,   last_ovf: 0, last_n: 3};
    vt[1] = '{nf: 5,  nl: 2,  big: 0, pts: 0, dones: 0, rerrs: 1, last_bcd: 32,   last_ovf: 0, last_n: 3};
    vt[2] = '{nf: 63, nl: 63, big: 0, pts: 1, dones: 1, rerrs: 0, last_bcd: 8132, last_ovf: 0, last_n: 63};
    vt[3] = '{nf: 63, nl: 63, big: 1, pts: 1, dones: 1, rerrs: 0, last_bcd: 9999, last_ovf: 1, last_n: 63};
    vt[4] = '{nf: 7,  nl: 7,  big: 0, pts: 1, dones: 1, rerrs: 0, last_bcd: 124,  last_ovf: 0, last_n: 7};
    vt[5] = '{nf: 62, nl: 63, big: 0, pts: 2, dones: 1, rerrs: 0, last_bcd: 8132, last_ovf: 0, last_n: 63};

    #1 reset = 1'b1;
    #1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_cur_n", int'(o_cur_n), 0);
    check("rst_ovf", int'(o_ovf), 0);
    check("rst_bcd_bin", int'(bus.bcd_bin), 0);
    check("rst_eng_start", int'(bus.eng_start), 0);
    check("rst_done_tick", int'(o_done_tick), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
`ifdef SWEEP_CONT_EN
      if (vt[i].rerrs == 0) continue;
`endif
      force_big = vt[i].big;
      e0 = eng_cnt; b0 = bcd_cnt; d0 = done_cnt; r0 = rerr_cnt;
      pulse_start(vt[i].nf, vt[i].nl);
      wait_done(d0, r0, ok);
      check($sformatf("v%0d_finished", i), int'(ok), 1);
      check($sformatf("v%0d_eng_starts", i), eng_cnt - e0, vt[i].pts);
      check($sformatf("v%0d_bcd_starts", i), bcd_cnt - b0, vt[i].pts);
      check($sformatf("v%0d_done_ticks", i), done_cnt - d0, vt[i].dones);
      check($sformatf("v%0d_range_errs", i), rerr_cnt - r0, vt[i].rerrs);
      check($sformatf("v%0d_bcd_bin", i), int'(bus.bcd_bin), vt[i].last_bcd);
      check($sformatf("v%0d_ovf", i), int'(o_ovf), vt[i].last_ovf);
      check($sformatf("v%0d_cur_n", i), int'(o_cur_n), vt[i].last_n);
      check($sformatf("v%0d_busy", i), int'(o_busy), 0);
    end
    force_big = 1'b0;

`ifndef SWEEP_CONT_EN
    // Basic sweep 0..3 was the first to push into the queue.
    check("basic_q_len_ok", int'(bcd_q.size() >= 4), 1);
    if (bcd_q.size() >= 4) begin
      check("basic_bcd0", bcd_q[0], 5);
      check("basic_bcd1", bcd_q[1], 10);
      check("basic_bcd2", bcd_q[2], 19);
      check("basic_bcd3", bcd_q[3], 32);
    end
`endif

    // Stop during calc of n=2.
    e0 = eng_cnt; b0 = bcd_cnt; d0 = done_cnt; r0 = rerr_cnt;
    pulse_start(0, 10);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (eng_cnt >= e0 + 3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("stop_reached_n2", int'(ok), 1);
    pulse_stop();
    wait_done(d0, r0, ok);
    check("stop_finished", int'(ok), 1);
    check("stop_eng_starts", eng_cnt - e0, 3);
    check("stop_bcd_starts", bcd_cnt - b0, 3);
    check("stop_done_ticks", done_cnt - d0, 1);
    check("stop_bcd_bin", int'(bus.bcd_bin), 19);
    check("stop_cur_n", int'(o_cur_n), 2);
    check("stop_busy", int'(o_busy), 0);

    // Start while busy is ignored, then reset during conv.
    e0 = eng_cnt; b0 = bcd_cnt;
    pulse_start(0, 3);
    pulse_start(9, 9);
    check("busy_start_cur_n", int'(o_cur_n), 0);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (bcd_cnt > b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("rstmid_reached_conv", int'(ok), 1);
    check("busy_start_eng_starts", eng_cnt - e0, 1);
    reset = 1'b1;
    #1;
    check("rstmid_busy", int'(o_busy), 0);
    check("rstmid_cur_n", int'(o_cur_n), 0);
    check("rstmid_bcd_bin", int'(bus.bcd_bin), 0);
    check("rstmid_bcd_start", int'(bus.bcd_start), 0);
    check("rstmid_ovf", int'(o_ovf), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

`ifndef SWEEP_CONT_EN
    e0 = eng_cnt; d0 = done_cnt; r0 = rerr_cnt;
    pulse_start(1, 2);
    wait_done(d0, r0, ok);
    check("post_rst_finished", int'(ok), 1);
    check("post_rst_eng_starts", eng_cnt - e0, 2);
    check("post_rst_bcd_bin", int'(bus.bcd_bin), 19);
    check("post_rst_cur_n", int'(o_cur_n), 2);
`else
    // Continuous sweep 1..2 wraps until stopped.
    b0 = bcd_q.size(); d0 = done_cnt; r0 = rerr_cnt;
    pulse_start(1, 2);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bcd_q.size() >= b0 + 5) begin
        ok = 1'b1;
        break;
      end
    end
    check("cont_got_points", int'(ok), 1);
    if (ok) begin
      check("cont_bcd0", bcd_q[b0], 10);
      check("cont_bcd1", bcd_q[b0 + 1], 19);
      check("cont_bcd2", bcd_q[b0 + 2], 10);
      check("cont_bcd3", bcd_q[b0 + 3], 19);
      check("cont_bcd4", bcd_q[b0 + 4], 10);
    end
    check("cont_no_done_yet", done_cnt - d0, 0);
    check("cont_busy", int'(o_busy), 1);
    pulse_stop();
    wait_done(d0, r0, ok);
    check("cont_finished", int'(ok), 1);
    e1 = eng_cnt;
    repeat (40) @(negedge clk);
    check("cont_done_ticks", done_cnt - d0, 1);
    check("cont_no_more_eng", eng_cnt - e1, 0);
    check("cont_busy_after", int'(o_busy), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
